// File: rtl/nv_fifo_ctrl_61x514.sv
// Valid/ready FIFO controller for the 61x514 two-port flop RAM.
// Drives the RAM write port directly from the write stream. Reads go through
// the RAM's two-stage pipeline: the address register (stage 1), then the output
// register (stage 2). Stage 2 valid is the read stream's valid. Occupancy covers
// stored and in-flight entries, so no address held in a pipe stage can be
// overwritten.
module nv_fifo_ctrl_61x514 #(
  parameter int DEPTH = 61,
  parameter int WIDTH = 514,
  parameter int AW    = 6
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    fifo_occ,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL_OCC = AW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] occ;
  logic [AW-1:0] unread;
  logic          s1_vld;
  logic          s2_vld;
  logic          wr_acc;
  logic          rd_pop;

  // Write side: ready comes from registered occupancy only, so a pop in the
  // same cycle as full never lets a write through.
  assign wr_prdy = (occ < FULL_OCC);
  assign wr_acc  = nvdla_core_rstn & wr_pvld & wr_prdy;
  assign ram_we  = wr_acc;
  assign ram_wa  = wr_ptr;
  assign ram_di  = wr_pd;

  // Read side: stage 2 advances when empty or when its entry is being popped;
  // stage 1 is refilled when it is empty or is handing over to stage 2.
  // Reset gating keeps the RAM enables and the read valid quiet during reset.
  assign rd_pvld = nvdla_core_rstn & s2_vld;
  assign rd_pop  = rd_pvld & rd_prdy;
  assign rd_pd   = ram_dout;
  assign ram_ore = nvdla_core_rstn & s1_vld & (~s2_vld | rd_prdy);
  assign ram_re  = nvdla_core_rstn & (unread != '0) & (~s1_vld | ram_ore);
  assign ram_ra  = rd_ptr;

  assign fifo_occ          = occ;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  // Write pointer: advances per accepted write, wrapping at the last entry.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer: advances each time an address is issued into stage 1.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      rd_ptr <= '0;
    end else if (ram_re) begin
      rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Unread count: entries whose write edge has passed but that have not yet
  // entered the read pipeline; being registered, it keeps reads off the
  // address being written this cycle.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      unread <= '0;
    end else begin
      case ({wr_acc, ram_re})
        2'b10:   unread <= unread + 1'b1;
        2'b01:   unread <= unread - 1'b1;
        default: unread <= unread;
      endcase
    end
  end

  // Occupancy: everything written and not yet popped, in-flight included.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      occ <= '0;
    end else begin
      case ({wr_acc, rd_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Stage 1 valid: RAM address register holds a live read address.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s1_vld <= 1'b0;
    end else if (ram_re) begin
      s1_vld <= 1'b1;
    end else if (ram_ore) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2 valid: RAM output register holds data presented on rd_pd.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s2_vld <= 1'b0;
    end else if (ram_ore) begin
      s2_vld <= 1'b1;
    end else if (rd_pop) begin
      s2_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_fifo_ctrl_61x514.sv
// Testbench for nv_fifo_ctrl_61x514: behavioural RAM, queue scoreboard,
// cycle table for latency, directed corner sequences and a random stream.
module tb_nv_fifo_ctrl_61x514;

  localparam int DEPTH = 61;
  localparam int WIDTH = 514;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [AW-1:0]    fifo_occ;
  logic [AW-1:0]    ram_wa;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic [AW-1:0]    ram_ra;
  logic             ram_re;
  logic             ram_ore;
  logic [WIDTH-1:0] ram_dout;
  logic [31:0]      pwrbus_ram_pd;
  logic [31:0]      ram_pwrbus_ram_pd;

  always #5 clk = ~clk;

  nv_fifo_ctrl_61x514 dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .fifo_occ          (fifo_occ),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_ore           (ram_ore),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  // Behavioural two-port RAM with registered read address and output.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) ram_dout <= mem[ra_q];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted payloads in order.
  logic [WIDTH-1:0] q[$];
  logic sb_acc, sb_pop;
  int   wr_wrap = 0;
  int   rd_wrap = 0;

  // Called just after inputs are driven on the falling edge.
  task automatic settle();
    #1;
    sb_acc = rstn && wr_pvld && (q.size() < DEPTH);
    sb_pop = rstn && rd_pvld && rd_prdy;
    if (rstn) begin
      chk("sb_occ", 32'(fifo_occ), 32'(q.size()));
      chk("sb_wr_prdy", 32'(wr_prdy), 32'(q.size() < DEPTH));
      chk("sb_ram_we", 32'(ram_we), 32'(sb_acc));
      if (ram_we) chkd("sb_ram_di", ram_di, wr_pd);
      if (rd_pvld) begin
        chk("sb_pvld_nonempty", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) chkd("sb_rd_pd", rd_pd, q[0]);
      end
    end
    if (ram_we && ram_wa == AW'(DEPTH - 1)) wr_wrap++;
    if (ram_re && ram_ra == AW'(DEPTH - 1)) rd_wrap++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rstn) q.delete();
    else begin
      if (sb_pop && q.size() != 0) void'(q.pop_front());
      if (sb_acc) q.push_back(wr_pd);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  typedef struct {
    logic        rstn;
    logic        wv;
    logic [15:0] wpd;
    logic        rr;
    logic        e_we;
    logic [5:0]  e_wa;
    logic        e_re;
    logic [5:0]  e_ra;
    logic        e_ore;
    logic        e_pvld;
    logic [15:0] e_pd;
    logic [5:0]  e_occ;
    logic        e_wprdy;
  } vec_t;

  vec_t tv[15];

  logic [543:0] rbits;
  int accepted;
  bit got;

  initial begin
    //          rstn wv wpd       rr  we wa  re ra  ore pvld pd        occ wprdy
    tv[0]  = '{1'b0,1'b1,16'h0007,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};
    tv[1]  = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};
    tv[2]  = '{1'b1,1'b1,16'h02A5,1'b1, 1'b1,6'd0,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};
    tv[3]  = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b1,6'd0,1'b0,1'b0,16'h0000,6'd1,1'b1};
    tv[4]  = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b1,1'b0,16'h0000,6'd1,1'b1};
    tv[5]  = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b1,16'h02A5,6'd1,1'b1};
    tv[6]  = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};
    tv[7]  = '{1'b1,1'b1,16'h0011,1'b0, 1'b1,6'd1,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};
    tv[8]  = '{1'b1,1'b1,16'h0022,1'b0, 1'b1,6'd2,1'b1,6'd1,1'b0,1'b0,16'h0000,6'd1,1'b1};
    tv[9]  = '{1'b1,1'b0,16'h0000,1'b0, 1'b0,6'd0,1'b1,6'd2,1'b1,1'b0,16'h0000,6'd2,1'b1};
    tv[10] = '{1'b1,1'b0,16'h0000,1'b0, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b1,16'h0011,6'd2,1'b1};
    tv[11] = '{1'b1,1'b0,16'h0000,1'b0, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b1,16'h0011,6'd2,1'b1};
    tv[12] = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b1,1'b1,16'h0011,6'd2,1'b1};
    tv[13] = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b1,16'h0022,6'd1,1'b1};
    tv[14] = '{1'b1,1'b0,16'h0000,1'b1, 1'b0,6'd0,1'b0,6'd0,1'b0,1'b0,16'h0000,6'd0,1'b1};

    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    pwrbus_ram_pd = 32'hA5C3_0F1E;
    @(negedge clk);
    step();
    step();
    #1 chk("pwrbus_pass", ram_pwrbus_ram_pd, 32'hA5C3_0F1E);

    // Latency / pipeline table.
    for (int i = 0; i < 15; i++) begin
      rstn = tv[i].rstn; wr_pvld = tv[i].wv; wr_pd = WIDTH'(tv[i].wpd); rd_prdy = tv[i].rr;
      settle();
      chk("tv_we", 32'(ram_we), 32'(tv[i].e_we));
      if (tv[i].e_we) chk("tv_wa", 32'(ram_wa), 32'(tv[i].e_wa));
      chk("tv_re", 32'(ram_re), 32'(tv[i].e_re));
      if (tv[i].e_re) chk("tv_ra", 32'(ram_ra), 32'(tv[i].e_ra));
      chk("tv_ore", 32'(ram_ore), 32'(tv[i].e_ore));
      chk("tv_pvld", 32'(rd_pvld), 32'(tv[i].e_pvld));
      if (tv[i].e_pvld) chkd("tv_pd", rd_pd, WIDTH'(tv[i].e_pd));
      chk("tv_occ", 32'(fifo_occ), 32'(tv[i].e_occ));
      chk("tv_wprdy", 32'(wr_prdy), 32'(tv[i].e_wprdy));
      advance();
    end

    // Fill to full with backpressure, then refuse the extra write.
    rd_prdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_pvld = 1'b1; wr_pd = WIDTH'(i);
      step();
    end
    wr_pvld = 1'b1; wr_pd = WIDTH'(999);
    settle();
    chk("full_wprdy", 32'(wr_prdy), 32'(0));
    chk("full_we", 32'(ram_we), 32'(0));
    chk("full_occ", 32'(fifo_occ), 32'(DEPTH));
    advance();
    wr_pvld = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Full with simultaneous pop: write refused, accepted next cycle.
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = WIDTH'(777);
    settle();
    chk("fullpop_we", 32'(ram_we), 32'(0));
    chk("fullpop_pvld", 32'(rd_pvld), 32'(1));
    chkd("fullpop_pd", rd_pd, WIDTH'(0));
    advance();
    rd_prdy = 1'b0;
    settle();
    chk("fullpop_next_wprdy", 32'(wr_prdy), 32'(1));
    chk("fullpop_next_we", 32'(ram_we), 32'(1));
    advance();
    wr_pvld = 1'b0;
    settle();
    chk("fullpop_occ", 32'(fifo_occ), 32'(DEPTH));
    advance();

    // Drain: one pop per cycle, in order (scoreboard checks data).
    rd_prdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("drain_pvld", 32'(rd_pvld), 32'(1));
      advance();
    end
    settle();
    chk("drain_done_pvld", 32'(rd_pvld), 32'(0));
    chk("drain_done_occ", 32'(fifo_occ), 32'(0));
    advance();

    // Backpressure stall with three entries queued.
    rd_prdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_pvld = 1'b1; wr_pd = WIDTH'(16'hA0 + i);
      step();
    end
    wr_pvld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_pvld", 32'(rd_pvld), 32'(1));
      chkd("stall_pd", rd_pd, WIDTH'(16'hA0));
      chk("stall_ore", 32'(ram_ore), 32'(0));
      chk("stall_re", 32'(ram_re), 32'(0));
      advance();
    end
    rd_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("release_pvld", 32'(rd_pvld), 32'(1));
      chkd("release_pd", rd_pd, WIDTH'(16'hA0 + i));
      advance();
    end
    settle();
    chk("release_empty", 32'(rd_pvld), 32'(0));
    advance();

    // Reset mid-stream with both pipe stages occupied.
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1; wr_pd = WIDTH'(16'h100 + i);
      step();
    end
    wr_pvld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rstn = 1'b0; wr_pvld = 1'b1; rd_prdy = 1'b1;
    settle();
    chk("rst1_we", 32'(ram_we), 32'(0));
    chk("rst1_re", 32'(ram_re), 32'(0));
    chk("rst1_ore", 32'(ram_ore), 32'(0));
    chk("rst1_pvld", 32'(rd_pvld), 32'(0));
    advance();
    settle();
    chk("rst2_we", 32'(ram_we), 32'(0));
    chk("rst2_re", 32'(ram_re), 32'(0));
    chk("rst2_ore", 32'(ram_ore), 32'(0));
    chk("rst2_pvld", 32'(rd_pvld), 32'(0));
    chk("rst2_occ", 32'(fifo_occ), 32'(0));
    advance();
    rstn = 1'b1; wr_pvld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("post_rst_pvld", 32'(rd_pvld), 32'(0));
      advance();
    end
    wr_pvld = 1'b1; wr_pd = WIDTH'(1);
    step();
    wr_pvld = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      settle();
      if (rd_pvld) begin
        got = 1'b1;
        chkd("post_rst_first", rd_pd, WIDTH'(1));
      end
      advance();
    end
    chk("post_rst_timeout", 32'(got), 32'(1));

    // Random concurrent stream: 200 writes, 50% read backpressure.
    wr_wrap = 0; rd_wrap = 0; accepted = 0;
    for (int c = 0; c < 3000 && accepted < 200; c++) begin
      for (int j = 0; j < 17; j++) rbits[j*32 +: 32] = $urandom();
      wr_pvld = ($urandom_range(3) != 0);
      wr_pd   = rbits[WIDTH-1:0];
      rd_prdy = $urandom_range(1);
      settle();
      if (sb_acc) accepted++;
      advance();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    for (int c = 0; c < 300 && q.size() != 0; c++) step();
    for (int c = 0; c < 2; c++) step();
    chk("rand_accepted", 32'(accepted), 32'(200));
    chk("rand_queue_empty", 32'(q.size()), 32'(0));
    chk("rand_wr_wraps", 32'(wr_wrap >= 3), 32'(1));
    chk("rand_rd_wraps", 32'(rd_wrap >= 3), 32'(1));
    settle();
    chk("rand_final_occ", 32'(fifo_occ), 32'(0));
    chk("rand_final_pvld", 32'(rd_pvld), 32'(0));
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
